// File: rtl/sipo_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sipo_pkg
// Description : Shared types and defaults for the SIPO deframer.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_deframer_if.sv
`default_nettype none
// ============================================================================
// Interface   : sipo_deframer_if
// Description : Serial input and parallel valid/ready output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deframer_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             shift_en;
    logic             sync;
    logic             data_ready;
    logic             ovr_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             busy;

    modport master (
        output serial_in, shift_en, sync, data_ready, ovr_clr,
        input  data_out, data_valid, overrun, busy
    );

    modport slave (
        input  serial_in, shift_en, sync, data_ready, ovr_clr,
        output data_out, data_valid, overrun, busy
    );
endinterface : sipo_deframer_if
`default_nettype wire

// File: rtl/sipo_deframer_shift.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift
// Description : Shift register and bit counter; flags the completing take.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             clear,
    input  wire logic             serial_in_i,
    input  wire logic             take_i,
    input  wire logic             sync_i,
    output logic      [WIDTH-1:0] word_o,
    output logic                  done_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q;
        done_o  = 1'b0;
        if (take_i) begin
            if (sync_i) begin
                sr_d    = WIDTH'(serial_in_i);
                cnt_inc = CW'(1);
            end else begin
                sr_d    = (sr_q << 1) | WIDTH'(serial_in_i);
                cnt_inc = cnt_q + CW'(1);
            end
            if (cnt_inc == CW'(WIDTH)) begin
                done_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    // The completed word is the post-shift image, so it is valid on done_o.
    assign word_o = sr_d;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule : sipo_shift
`default_nettype wire

// File: rtl/sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deframer
// Description : Sync-aligned serial-to-parallel receiver with valid/ready out.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      clear,
    sipo_deframer_if.slave bus
);
    sipo_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             w_take;
    logic             w_done;
    logic [WIDTH-1:0] w_word;

    assign w_take = bus.shift_en && (bus.sync || (state_q == SHIFT));

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk        (clk),
        .clear      (clear),
        .serial_in_i(bus.serial_in),
        .take_i     (w_take),
        .sync_i     (bus.sync),
        .word_o     (w_word),
        .done_o     (w_done)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (w_take) begin
            state_d = w_done ? IDLE : SHIFT;
        end

        if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end

        // Overrun set is evaluated after the clear so that set wins.
        if (w_done) begin
            if (!valid_q || bus.data_ready) begin
                data_d  = w_word;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q == SHIFT);
endmodule : sipo_deframer
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deframer
// Description : Scoreboard bench for sipo_deframer, WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deframer;
    localparam int W = 4;

    logic clk;
    logic clear;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];

    sipo_deframer_if #(.WIDTH(W)) bus ();

    sipo_deframer #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take(input logic b, input logic s);
        bus.serial_in = b;
        bus.sync      = s;
        bus.shift_en  = 1'b1;
        @(posedge clk);
        #1;
        bus.shift_en  = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit push);
        if (push) exp_q.push_back(w);
        for (int i = W - 1; i >= 0; i--) begin
            take(w[i], i == W - 1);
        end
    endtask

    // Each sample with valid&ready high corresponds to one acceptance edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (clear && bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", 32'(bus.data_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        clear          = 1'b0;
        bus.serial_in  = 1'b0;
        bus.shift_en   = 1'b0;
        bus.sync       = 1'b0;
        bus.data_ready = 1'b0;
        bus.ovr_clr    = 1'b0;
        idle(2);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        clear = 1'b1;
        idle(1);

        // Basic word with continuous ready
        bus.data_ready = 1'b1;
        exp_q.push_back(4'b1011);
        take(1'b1, 1'b1);
        check("busy_after_sync", 32'(bus.busy), 32'h1);
        take(1'b0, 1'b0);
        take(1'b1, 1'b0);
        take(1'b1, 1'b0);
        check("t1_valid", 32'(bus.data_valid), 32'h1);
        check("t1_data", 32'(bus.data_out), 32'hB);
        check("t1_busy_done", 32'(bus.busy), 32'h0);
        idle(1);
        check("t1_valid_drop", 32'(bus.data_valid), 32'h0);

        // Bits before sync are ignored
        take(1'b0, 1'b0);
        take(1'b1, 1'b0);
        take(1'b1, 1'b0);
        check("t2_busy_unaligned", 32'(bus.busy), 32'h0);
        check("t2_no_valid", 32'(bus.data_valid), 32'h0);
        send_word(4'b1100, 1'b1);
        check("t2_data", 32'(bus.data_out), 32'hC);
        idle(1);

        // Resync mid-word discards partial
        take(1'b1, 1'b1);
        take(1'b0, 1'b0);
        send_word(4'b0110, 1'b1);
        check("t3_data", 32'(bus.data_out), 32'h6);
        check("t3_overrun", 32'(bus.overrun), 32'h0);
        idle(1);

        // Overrun with ready low
        bus.data_ready = 1'b0;
        send_word(4'b1010, 1'b1);
        send_word(4'b0101, 1'b0);
        check("t4_data_held", 32'(bus.data_out), 32'hA);
        check("t4_overrun", 32'(bus.overrun), 32'h1);
        check("t4_valid", 32'(bus.data_valid), 32'h1);
        bus.ovr_clr = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
        check("t4_ovr_clr", 32'(bus.overrun), 32'h0);
        bus.data_ready = 1'b1;
        idle(1);
        check("t4_accepted", 32'(bus.data_valid), 32'h0);

        // Completion on the same edge as acceptance
        bus.data_ready = 1'b0;
        send_word(4'b0011, 1'b1);
        exp_q.push_back(4'b1001);
        take(1'b1, 1'b1);
        take(1'b0, 1'b0);
        take(1'b0, 1'b0);
        bus.data_ready = 1'b1;
        take(1'b1, 1'b0);
        check("t5_data", 32'(bus.data_out), 32'h9);
        check("t5_valid", 32'(bus.data_valid), 32'h1);
        check("t5_overrun", 32'(bus.overrun), 32'h0);
        idle(1);
        check("t5_valid_drop", 32'(bus.data_valid), 32'h0);

        // Overrun set beats ovr_clr on the same edge
        bus.data_ready = 1'b0;
        send_word(4'b1111, 1'b1);
        take(1'b0, 1'b1);
        take(1'b0, 1'b0);
        take(1'b0, 1'b0);
        bus.ovr_clr = 1'b1;
        take(1'b0, 1'b0);
        bus.ovr_clr = 1'b0;
        check("t6_set_wins", 32'(bus.overrun), 32'h1);
        check("t6_data_held", 32'(bus.data_out), 32'hF);
        bus.ovr_clr = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
        check("t6_cleared", 32'(bus.overrun), 32'h0);
        bus.data_ready = 1'b1;
        idle(1);
        bus.data_ready = 1'b0;

        // Asynchronous clear mid-word with a held word
        send_word(4'b1110, 1'b0);
        take(1'b1, 1'b1);
        take(1'b0, 1'b0);
        check("t7_busy_pre", 32'(bus.busy), 32'h1);
        check("t7_valid_pre", 32'(bus.data_valid), 32'h1);
        clear = 1'b0;
        #1;
        check("t7_clr_data", 32'(bus.data_out), 32'h0);
        check("t7_clr_valid", 32'(bus.data_valid), 32'h0);
        check("t7_clr_overrun", 32'(bus.overrun), 32'h0);
        check("t7_clr_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        clear = 1'b1;
        bus.data_ready = 1'b1;
        send_word(4'b1101, 1'b1);
        check("t7_data_after", 32'(bus.data_out), 32'hD);
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_sipo_deframer
`default_nettype wire

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in parallel-out receive stage that sits directly downstream of the team's 4-bit parallel-in serial-out shifter. It samples the serial bit stream on qualified clock edges, aligns word boundaries on a start marker, and assembles `WIDTH`-bit words. Each completed word is presented on a registered parallel output under a valid/ready handshake, with a sticky overrun flag for words the consumer did not accept in time.

## Interface
- `WIDTH`, 4: bits per word; legal range 2–16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `serial_in` input 1: serial data bit; sampled only when `shift_en`=1.
- `shift_en` input 1: bit-valid strobe; one bit is consumed per clock with `shift_en`=1.
- `sync` input 1: start-of-word marker; meaningful only with `shift_en`=1.
- `data_ready` input 1: consumer accepts `data_out` on a cycle where `data_valid` and `data_ready` are both 1.
- `ovr_clr` input 1: synchronous clear of `overrun`.
- `data_out` output `WIDTH`: last completed word; first received bit is in `data_out[WIDTH-1]` (MSB-first).
- `data_valid` output 1: `data_out` holds an unaccepted word.
- `overrun` output 1: sticky; a completed word was dropped.
- `busy` output 1: a word is partially assembled (state SHIFT).

## Operation
- States: IDLE, SHIFT. Internal registers: shift register `sr[WIDTH-1:0]`, bit counter `cnt` of width clog2(WIDTH+1), holding register, `data_valid`, `overrun`.
- A bit is "taken" on any edge with `shift_en`=1 and `sync`=1, or with `shift_en`=1 in SHIFT.
- `shift_en`=0: all state holds, whatever `sync` is.
- IDLE: `shift_en`=1 with `sync`=0 ignores the bit (no alignment yet). `shift_en`=1 with `sync`=1 loads `sr[0]`←`serial_in`, sets `cnt`=1 and enters SHIFT.
- SHIFT: `shift_en`=1 with `sync`=0 shifts `sr`←{`sr[WIDTH-2:0]`,`serial_in`} and increments `cnt`.
- SHIFT, `sync`=1 mid-word: the partial word is discarded without any flag. The bit restarts the word as in IDLE, with `cnt`=1.
- Word complete: the taken bit brings `cnt` to `WIDTH`. The assembled word {`sr[WIDTH-2:0]`,`serial_in`} is offered for transfer, and the block returns to IDLE with `cnt`=0. A `sync`=1 on the following take starts the next word with no gap.
- WIDTH=… degenerate case: with `sync`=1 on every take, no word completes unless `WIDTH` bits follow the marker.
- Transfer rule on a completion edge:
  - `data_valid`=0, or `data_valid`=1 with `data_ready`=1: the holding register loads the new word and `data_valid`=1.
  - `data_valid`=1 with `data_ready`=0: the new word is dropped, the held word is preserved and `overrun`←1.
- Without a completion, `data_valid`=1 with `data_ready`=1 clears `data_valid` on that edge.
- `overrun`: set as above and cleared by `ovr_clr`=1. If set and clear happen on the same edge, set wins.
- Asserting `clear` (low) at any time, including mid-word, forces: state IDLE, `cnt`=0, `sr`=0, `data_out`=0, `data_valid`=0, `overrun`=0, `busy`=0. No partial word survives reset.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset values: `data_out`=0, `data_valid`=0, `overrun`=0, `busy`=0.
- Latency: with the sync bit taken at edge 0 and `shift_en` continuous, the last bit is taken at edge `WIDTH-1`. `data_valid`=1 and the word are visible immediately after that edge.
- Throughput: one word per `WIDTH` takes, provided the consumer holds `data_ready`=1.
- `busy`=1 after any edge that leaves the block in SHIFT.
- Reset deassertion is synchronised externally; the block takes no action on the deassertion edge itself.

## Structure
- Shared package `sipo_pkg`: state enum `sipo_state_t` {IDLE, SHIFT} and the default `WIDTH` constant.
- One natural sub-module: `sipo_shift`, holding `sr`, `cnt` and the completion strobe.
- The top level holds the FSM, the holding register and the handshake/overrun logic.

## Test plan
- WIDTH=4, reset then continuous `shift_en`: sync with bits 1,0,1,1 and `data_ready`=1 → `data_out`=4'b1011 and `data_valid` high one cycle after the 4th bit, low the next cycle.
- Bits before any sync (0,1,1) followed by sync+1,1,0,0 → only `data_out`=4'b1100 is produced; the leading bits are ignored.
- Sync+1,0 then a new sync+0,1,1,0 → `data_out`=4'b0110 and `overrun`=0; the first partial word is discarded.
- `data_ready`=0 across two complete words A=4'b1010 then B=4'b0101 → `data_out` stays 4'b1010, `overrun`=1. Pulsing `ovr_clr` → `overrun`=0.
- Word completes on the same edge that `data_ready`=1 accepts the previous word → new word loads, `data_valid` stays 1, `overrun`=0.
- `clear` pulsed low after 2 bits of a word and during `data_valid`=1 → all outputs are 0 immediately. The next sync plus 4 bits yields a correct word.
